// File: rtl/common_pkg.sv
// ----------------------------------------------------------------------------
// common: data-bus transaction types shared between the core and the bus.
//
//   dbus_req_t  : valid, addr (byte address), size (0=byte .. 3=double),
//                 strobe (byte enables, zero for reads), data (lane-aligned)
//   dbus_resp_t : data_ok (one-cycle completion), data (full 64-bit beat)
// ----------------------------------------------------------------------------
package common;

    localparam int BUS_W = 64;

    typedef struct packed {
        logic             valid;
        logic [BUS_W-1:0] addr;
        logic [2:0]       size;
        logic [7:0]       strobe;
        logic [BUS_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic             data_ok;
        logic [BUS_W-1:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// ----------------------------------------------------------------------------
// pipes: inter-stage bundles of the five-stage pipeline, plus the memory
// stage state encoding and access-size helpers.
//
//   msize_t        : access size encoding (0=byte, 1=half, 2=word, 3=double)
//   mem_state_t    : memory stage FSM states
//   control_t      : decoded control bits carried down the pipe
//   execute_data_t : execute -> memory bundle
//   memory_data_t  : memory -> writeback bundle
// ----------------------------------------------------------------------------
package pipes;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2,
        MSIZE_D = 2'd3
    } msize_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   mem_unsigned;
        msize_t msize;
    } control_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [31:0]       raw_instr;
        logic [4:0]        dst;
        logic [4:0]        ra1;
        logic [4:0]        ra2;
        control_t          ctl;
        logic [DATA_W-1:0] result;   // ALU result or effective address
        logic [DATA_W-1:0] memdata;  // store source
    } execute_data_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [31:0]       raw_instr;
        logic [4:0]        dst;
        logic [4:0]        ra1;
        logic [4:0]        ra2;
        control_t          ctl;
        logic [DATA_W-1:0] writedata;
    } memory_data_t;

    // Byte-enable pattern of an access before lane alignment: 2^(2^size)-1.
    function automatic logic [7:0] size_strobe(input msize_t size);
        case (size)
            MSIZE_B: return 8'h01;
            MSIZE_H: return 8'h03;
            MSIZE_W: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input msize_t size);
        case (size)
            MSIZE_B: return 3'b000;
            MSIZE_H: return 3'b001;
            MSIZE_W: return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_muxword.sv
// ----------------------------------------------------------------------------
// muxword: load-data extraction. Shifts the addressed bytes of a 64-bit bus
// beat down to bit 0, truncates to the access size and sign- or zero-extends.
//
//   data        in  64  raw bus beat
//   offset      in  3   byte offset within the beat (addr[2:0])
//   size        in      access size (msize_t)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 64  extended load value
// ----------------------------------------------------------------------------
module muxword
    import pipes::*;
(
    input  logic [63:0] data,
    input  logic [2:0]  offset,
    input  msize_t      size,
    input  logic        is_unsigned,
    output logic [63:0] result
);

    logic [63:0] shifted;

    assign shifted = data >> {offset, 3'b000};

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch can be inferred if the case is ever edited.
        result = '0;
        case (size)
            MSIZE_B: result = is_unsigned ? {56'd0, shifted[7:0]}
                                          : {{56{shifted[7]}}, shifted[7:0]};
            MSIZE_H: result = is_unsigned ? {48'd0, shifted[15:0]}
                                          : {{48{shifted[15]}}, shifted[15:0]};
            MSIZE_W: result = is_unsigned ? {32'd0, shifted[31:0]}
                                          : {{32{shifted[31]}}, shifted[31:0]};
            MSIZE_D: result = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// ----------------------------------------------------------------------------
// memory_stage: memory-access stage between execute and writeback.
// Non-memory instructions pass through in one cycle. Loads and stores are
// captured into a holding register and run over the data bus; the stage
// stalls upstream until the bus answers with data_ok.
//
//   clk       in   pipeline clock, rising edge
//   reset     in   synchronous active-low reset
//   dataE     in   execute bundle (sampled only in IDLE)
//   dreq      out  data-bus request, driven from the holding register
//   dresp     in   data-bus response
//   stallM    out  hold execute and earlier stages
//   dataM     out  registered bundle to writeback
//   misalign  out  one-cycle misaligned-access pulse
//                  (only when MEM_MISALIGN_CHECK_EN is defined)
//
// Build option MEM_MISALIGN_CHECK_EN: misaligned accesses are not sent to the
// bus; they retire immediately with regwrite cleared and writedata = address.
// ----------------------------------------------------------------------------
module memory_stage
    import pipes::*;
    import common::*;
#(
    parameter int XLEN = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output logic          stallM,
    output memory_data_t  dataM
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic          misalign
`endif
);

    mem_state_t    state;
    execute_data_t hold;
    logic          is_mem_op;
    logic [XLEN-1:0] load_result;
    memory_data_t  pass_bundle;
    memory_data_t  done_bundle;

    assign is_mem_op = dataE.ctl.memread | dataE.ctl.memwrite;

    muxword u_muxword (
        .data        (dresp.data),
        .offset      (hold.result[2:0]),
        .size        (hold.ctl.msize),
        .is_unsigned (hold.ctl.mem_unsigned),
        .result      (load_result)
    );

    // Bundles presented to writeback: straight from execute, or from the
    // holding register once the bus access completes.
    always_comb begin
        pass_bundle           = '0;
        pass_bundle.valid     = dataE.valid;
        pass_bundle.pc        = dataE.pc;
        pass_bundle.raw_instr = dataE.raw_instr;
        pass_bundle.dst       = dataE.dst;
        pass_bundle.ra1       = dataE.ra1;
        pass_bundle.ra2       = dataE.ra2;
        pass_bundle.ctl       = dataE.ctl;
        pass_bundle.writedata = dataE.result;

        done_bundle           = '0;
        done_bundle.valid     = hold.valid;
        done_bundle.pc        = hold.pc;
        done_bundle.raw_instr = hold.raw_instr;
        done_bundle.dst       = hold.dst;
        done_bundle.ra1       = hold.ra1;
        done_bundle.ra2       = hold.ra2;
        done_bundle.ctl       = hold.ctl;
        done_bundle.writedata = hold.ctl.memread ? load_result : hold.result;
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic         misaligned;
    memory_data_t misalign_bundle;

    always_comb begin
        misaligned = is_mem_op &&
                     ((dataE.result[2:0] & align_mask(dataE.ctl.msize)) != 3'b000);
        misalign_bundle              = pass_bundle;
        misalign_bundle.ctl.regwrite = 1'b0;
    end
`endif

    // Request fields come only from the holding register, so they cannot
    // move while the access is outstanding.
    always_comb begin
        dreq        = '0;
        dreq.valid  = (state == MEM_BUSY);
        dreq.addr   = hold.result;
        dreq.size   = {1'b0, hold.ctl.msize};
        dreq.strobe = hold.ctl.memwrite
                    ? (size_strobe(hold.ctl.msize) << hold.result[2:0])
                    : 8'h00;
        dreq.data   = hold.memdata << {hold.result[2:0], 3'b000};
    end

    // Release upstream in the data_ok cycle; the next instruction is then
    // sampled on the edge after the one that retires this access.
    assign stallM = (state == MEM_BUSY) && !dresp.data_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the holding register is reset too (it is a single
            // register, not an array), so dreq fields read as zero after
            // reset instead of stale or X values.
            state <= MEM_IDLE;
            hold  <= '0;
            dataM <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge values of the others.
`ifdef MEM_MISALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
            case (state)
                MEM_IDLE: begin
                    if (!dataE.valid) begin
                        dataM <= '0;
                    end else if (!is_mem_op) begin
                        dataM <= pass_bundle;
`ifdef MEM_MISALIGN_CHECK_EN
                    end else if (misaligned) begin
                        dataM    <= misalign_bundle;
                        misalign <= 1'b1;
`endif
                    end else begin
                        hold  <= dataE;
                        state <= MEM_BUSY;
                        dataM <= '0;
                    end
                end
                MEM_BUSY: begin
                    if (dresp.data_ok) begin
                        dataM <= done_bundle;
                        state <= MEM_IDLE;
                    end else begin
                        dataM <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// ----------------------------------------------------------------------------
// tb_memory_stage: directed bench for memory_stage. Each stimulus vector
// pushes its expected writeback bundle and, for memory ops, its expected bus
// request into queues. A monitor pops writeback expectations whenever dataM
// is valid; a bus model pops request expectations, answers after the vector's
// wait count and checks request stability while waiting.
// ----------------------------------------------------------------------------
module tb_memory_stage;
    import pipes::*;
    import common::*;

    typedef struct {
        string        name;
        memory_data_t m;
    } mexp_t;

    typedef struct {
        string       name;
        dbus_req_t   req;
        int          waits;
        logic [63:0] rdata;
    } bexp_t;

    logic          clk;
    logic          reset;
    execute_data_t dataE;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    logic          stallM;
    memory_data_t  dataM;
`ifdef MEM_MISALIGN_CHECK_EN
    logic          misalign;
`endif

    memory_stage #(.XLEN(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .dataE  (dataE),
        .dreq   (dreq),
        .dresp  (dresp),
        .stallM (stallM),
        .dataM  (dataM)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign (misalign)
`endif
    );

    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    mexp_t exp_m[$];
    bexp_t bus_q[$];
    int    valid_cycles[$];
    logic  bus_auto = 1'b1;
    logic [63:0] pc_ctr = 64'h8000_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string why);
        n_vec++;
        n_bad++;
        $display("FAIL %s: %s", name, why);
    endtask

    function automatic control_t mk_ctl(input logic rw, input logic mr, input logic mw,
                                        input logic uns, input msize_t sz);
        control_t c;
        c.regwrite     = rw;
        c.memread      = mr;
        c.memwrite     = mw;
        c.mem_unsigned = uns;
        c.msize        = sz;
        return c;
    endfunction

    function automatic execute_data_t mk_instr(input control_t ctl, input logic [63:0] result,
                                               input logic [63:0] memdata);
        execute_data_t e;
        e           = '0;
        e.valid     = 1'b1;
        e.pc        = pc_ctr;
        e.raw_instr = {pc_ctr[29:0], 2'b11};
        e.dst       = pc_ctr[6:2];
        e.ra1       = 5'd1;
        e.ra2       = 5'd2;
        e.ctl       = ctl;
        e.result    = result;
        e.memdata   = memdata;
        return e;
    endfunction

    function automatic memory_data_t expect_m(input execute_data_t e, input logic [63:0] wd);
        memory_data_t m;
        m           = '0;
        m.valid     = 1'b1;
        m.pc        = e.pc;
        m.raw_instr = e.raw_instr;
        m.dst       = e.dst;
        m.ra1       = e.ra1;
        m.ra2       = e.ra2;
        m.ctl       = e.ctl;
        m.writedata = wd;
        return m;
    endfunction

    // Writeback monitor.
    initial begin
        mexp_t x;
        forever begin
            @(negedge clk);
            if (reset && dataM.valid) begin
                if (exp_m.size() == 0) begin
                    fail("dataM.unexpected", $sformatf("pc %0h wd %0h", dataM.pc, dataM.writedata));
                end else begin
                    x = exp_m.pop_front();
                    check({x.name, ".dataM"}, dataM, x.m);
                    valid_cycles.push_back(cyc);
                end
            end
        end
    end

    // Bus model.
    initial begin
        bexp_t cur;
        logic  busy_b;
        int    cnt;
        busy_b = 1'b0;
        cnt    = 0;
        dresp  = '0;
        forever begin
            @(negedge clk);
            if (bus_auto) begin
                dresp.data_ok = 1'b0;
                if (!reset) begin
                    busy_b = 1'b0;
                end else if (dreq.valid) begin
                    if (!busy_b) begin
                        if (bus_q.size() == 0) begin
                            fail("dreq.unexpected", $sformatf("addr %0h", dreq.addr));
                            dresp.data_ok = 1'b1;
                            dresp.data    = '0;
                        end else begin
                            cur = bus_q.pop_front();
                            check({cur.name, ".dreq"}, dreq, cur.req);
                            busy_b = 1'b1;
                            cnt    = 0;
                        end
                    end else begin
                        check({cur.name, ".dreq_hold"}, dreq, cur.req);
                    end
                    if (busy_b) begin
                        if (cnt == cur.waits) begin
                            dresp.data_ok = 1'b1;
                            dresp.data    = cur.rdata;
                            busy_b        = 1'b0;
                        end else begin
                            cnt++;
                        end
                    end
                end
            end
        end
    end

    // Present one instruction and follow the upstream stall protocol.
    // Entered and left at negedge+2.
    task automatic issue(input string name, input control_t ctl, input logic [63:0] result,
                         input logic [63:0] memdata, input int waits, input logic [63:0] rdata,
                         input logic [7:0] exp_strobe, input logic [63:0] exp_bdata,
                         input logic [63:0] exp_wd);
        execute_data_t e;
        mexp_t         me;
        bexp_t         be;
        int            stalls;
        pc_ctr  = pc_ctr + 64'd4;
        e       = mk_instr(ctl, result, memdata);
        me.name = name;
        me.m    = expect_m(e, exp_wd);
        exp_m.push_back(me);
        dataE = e;
        if (ctl.memread || ctl.memwrite) begin
            be.name       = name;
            be.req        = '0;
            be.req.valid  = 1'b1;
            be.req.addr   = result;
            be.req.size   = {1'b0, ctl.msize};
            be.req.strobe = exp_strobe;
            be.req.data   = exp_bdata;
            be.waits      = waits;
            be.rdata      = rdata;
            bus_q.push_back(be);
            @(posedge clk);
            stalls = 0;
            for (int g = 0; g < 200; g++) begin
                @(negedge clk);
                #2;
                if (!stallM) break;
                stalls++;
            end
            check({name, ".stall_cycles"}, stalls, waits);
            @(posedge clk);
            @(negedge clk);
            #2;
        end else begin
            @(posedge clk);
            @(negedge clk);
            #2;
            check({name, ".stallM"}, stallM, 1'b0);
        end
        check({name, ".dataM_on_time"}, exp_m.size(), 0);
        dataE = '0;
    endtask

    initial begin
        control_t      c;
        execute_data_t e;
        int            n;

        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        control_t      c;
        execute_data_t e;
        int            n;

        reset = 1'b0;
        dataE = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check("reset.dataM", dataM, '0);
        check("reset.dreq_valid", dreq.valid, 1'b0);
        check("reset.stallM", stallM, 1'b0);
        reset = 1'b1;

        //     name       ctl                                   result        memdata                waits rdata                  strobe bus data               writedata
        issue("add",  mk_ctl(1, 0, 0, 0, MSIZE_D), 64'h1234, 64'h0, 0, 64'h0, 8'h00, 64'h0, 64'h1234);
        issue("lb",   mk_ctl(1, 1, 0, 0, MSIZE_B), 64'h1003, 64'h0, 3, 64'h0000_0000_8000_0000,
              8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        issue("sh",   mk_ctl(0, 0, 1, 0, MSIZE_H), 64'h2006, 64'hBEEF, 1, 64'h0,
              8'hC0, 64'hBEEF_0000_0000_0000, 64'h2006);
        issue("lhu",  mk_ctl(1, 1, 0, 1, MSIZE_H), 64'h2006, 64'h0, 0, 64'hBEEF_0000_0000_0000,
              8'h00, 64'h0, 64'h0000_0000_0000_BEEF);
        issue("lh",   mk_ctl(1, 1, 0, 0, MSIZE_H), 64'h2006, 64'h0, 2, 64'hBEEF_0000_0000_0000,
              8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_BEEF);
        issue("lw",   mk_ctl(1, 1, 0, 0, MSIZE_W), 64'h3004, 64'h0, 0, 64'h8765_4321_0000_0000,
              8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321);
        issue("lwu",  mk_ctl(1, 1, 0, 1, MSIZE_W), 64'h3004, 64'h0, 1, 64'h8765_4321_0000_0000,
              8'h00, 64'h0, 64'h0000_0000_8765_4321);
        issue("sb",   mk_ctl(0, 0, 1, 0, MSIZE_B), 64'h3005, 64'h1234_5678_9ABC_DEF0, 0, 64'h0,
              8'h20, 64'hBCDE_F000_0000_0000, 64'h3005);
        issue("lbu",  mk_ctl(1, 1, 0, 1, MSIZE_B), 64'h4017, 64'h0, 0, 64'hA500_0000_0000_0000,
              8'h00, 64'h0, 64'h0000_0000_0000_00A5);

        // Back-to-back zero-wait ld, sd, ld.
        issue("b2b_ld0", mk_ctl(1, 1, 0, 0, MSIZE_D), 64'h4000, 64'h0, 0, 64'h0123_4567_89AB_CDEF,
              8'h00, 64'h0, 64'h0123_4567_89AB_CDEF);
        issue("b2b_sd",  mk_ctl(0, 0, 1, 0, MSIZE_D), 64'h4008, 64'hCAFE_F00D_DEAD_BEEF, 0, 64'h0,
              8'hFF, 64'hCAFE_F00D_DEAD_BEEF, 64'h4008);
        issue("b2b_ld1", mk_ctl(1, 1, 0, 0, MSIZE_D), 64'h4010, 64'h0, 0, 64'h1122_3344_5566_7788,
              8'h00, 64'h0, 64'h1122_3344_5566_7788);
        n = valid_cycles.size();
        if (n >= 3) begin
            check("b2b.gap0", valid_cycles[n-2] - valid_cycles[n-3], 2);
            check("b2b.gap1", valid_cycles[n-1] - valid_cycles[n-2], 2);
        end else begin
            fail("b2b.count", $sformatf("only %0d writeback bundles seen", n));
        end

        // Reset while IDLE with a valid ALU op presented.
        pc_ctr = pc_ctr + 64'd4;
        dataE  = mk_instr(mk_ctl(1, 0, 0, 0, MSIZE_D), 64'h77, 64'h0);
        reset  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_idle.dataM", dataM, '0);
        dataE = '0;
        reset = 1'b1;

        // Reset in the middle of an outstanding load; late data_ok ignored.
        bus_auto = 1'b0;
        dresp    = '0;
        pc_ctr   = pc_ctr + 64'd4;
        dataE    = mk_instr(mk_ctl(1, 1, 0, 0, MSIZE_D), 64'h5000, 64'h0);
        @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_busy.dreq_before", dreq.valid, 1'b1);
        check("rst_busy.stall_before", stallM, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_busy.dreq_valid", dreq.valid, 1'b0);
        check("rst_busy.dataM", dataM, '0);
        check("rst_busy.stallM", stallM, 1'b0);
        dataE = '0;
        reset = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        #2;
        dresp = '0;
        check("late_ok.dataM", dataM, '0);
        check("late_ok.dreq_valid", dreq.valid, 1'b0);
        bus_auto = 1'b1;

        issue("post_reset_add", mk_ctl(1, 0, 0, 0, MSIZE_D), 64'h55, 64'h0, 0, 64'h0,
              8'h00, 64'h0, 64'h55);

`ifdef MEM_MISALIGN_CHECK_EN
        begin
            mexp_t me;
            pc_ctr  = pc_ctr + 64'd4;
            e       = mk_instr(mk_ctl(1, 1, 0, 0, MSIZE_W), 64'h1002, 64'h0);
            me.name = "lw_misaligned";
            me.m    = expect_m(e, 64'h1002);
            me.m.ctl.regwrite = 1'b0;
            exp_m.push_back(me);
            dataE = e;
            @(posedge clk);
            @(negedge clk);
            #2;
            check("lw_misaligned.misalign", misalign, 1'b1);
            check("lw_misaligned.stallM", stallM, 1'b0);
            check("lw_misaligned.dataM_on_time", exp_m.size(), 0);
            dataE = '0;
            @(posedge clk);
            @(negedge clk);
            #2;
            check("lw_misaligned.pulse_end", misalign, 1'b0);
            check("lw_misaligned.dreq_valid", dreq.valid, 1'b0);
        end
`endif

        repeat (3) @(negedge clk);
        check("end.queues_empty", exp_m.size() + bus_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage of the five-stage pipeline. Sits between execute and writeback: registers each `execute_data_t` bundle from execute, runs loads and stores over the data bus with a valid/data_ok handshake, and presents a `memory_data_t` bundle to writeback. While a bus access is outstanding, it stalls the upstream stages.

## Interface
Parameters:
- `XLEN`, 64: datapath width; bus data is 64 bits, byte-addressed.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; state clears on a rising edge when `reset`=0.
- `dataE`  in  execute_data_t  upstream bundle.
  - Fields: `valid`, `pc`, `raw_instr`, `dst`, `ra1`, `ra2`, `ctl`, `result` (ALU result or effective address), `memdata` (store source).
- `dreq`  out  dbus_req_t  data-bus request: `valid`, `addr`, `size`, `strobe`, `data`.
- `dresp`  in  dbus_resp_t  data-bus response: `data_ok`, `data`.
- `stallM`  out  1  execute and earlier stages hold while 1.
- `dataM`  out  memory_data_t  registered bundle to writeback; `writedata` carries the load result or ALU result.
- `misalign`  out  1  one-cycle pulse on a misaligned access. Present only with `MEM_MISALIGN_CHECK_EN`.

## Operation
Two states:
- IDLE
- BUSY

IDLE, `dataE.valid`=0:
- `dataM` is loaded with zero. Zero `raw_instr` reads as a bubble downstream.

IDLE, `dataE.valid`=1, `ctl.memread`=`ctl.memwrite`=0:
- `dataM` <= the `dataE` fields, with `writedata`=`result`.
- Stay in IDLE.

IDLE, `dataE.valid`=1, memory op:
- Capture `dataE` into the holding register.
- Go to BUSY.
- `dataM` <= zero (bubble).

BUSY:
- `dreq.valid`=1, driven from the holding register.
  - `addr` = `result`.
  - `size` = `ctl.msize` (0=byte, 1=half, 2=word, 3=double).
  - `strobe` = (2^(2^size))-1 shifted left by `addr[2:0]`. Zero for loads.
  - `data` = `memdata` shifted left by 8*`addr[2:0]`.
- `dreq` fields stay constant until `data_ok`.

BUSY, `dresp.data_ok`=1:
- `dataM` <= the holding register.
- For loads, `writedata` = `dresp.data` shifted right by 8*`addr[2:0]`, truncated to the access size. It is sign-extended unless `ctl.mem_unsigned`=1.
- For stores, `writedata` = `result`.
- Go to IDLE.

`stallM` = (state==BUSY) && !`dresp.data_ok`.
- Upstream advances in the same cycle as `data_ok`.
- The next instruction is accepted on the following edge.

Upstream must hold `dataE` stable while `stallM`=1. This block samples `dataE` only in IDLE.

Reset, including mid-access:
- state = IDLE, `dataM` = 0, `dreq.valid` = 0 from the next cycle.
- A `data_ok` arriving after reset is ignored. The bus is reset with the core.

## Timing
- Non-memory instruction: one cycle, from `dataE` sampled to `dataM` visible.
- Memory op: 1 cycle accept, then N cycles in BUSY until `data_ok` (N ≥ 1). `dataM` is valid the cycle after `data_ok`.
  - Minimum is 2 cycles with zero bus wait.
- `dreq.valid` rises exactly one cycle after accept. It never drops before `data_ok`.
- `data_ok` seen in IDLE is ignored.
- Back-to-back loads have no idle gap on `dreq.valid` beyond the accept cycle.

## Configuration
`MEM_MISALIGN_CHECK_EN`:
- Defined:
  - Accept checks `addr` mod 2^size ≠ 0.
  - If misaligned, no bus request is issued and the state stays IDLE.
  - `misalign` pulses for one cycle.
  - `dataM` carries the instruction with `ctl.regwrite` forced to 0 and `writedata`=`addr`.
- Undefined:
  - The `misalign` port is absent.
  - All accesses go to the bus unchanged.

## Structure
Package `pipes`:
- `memory_data_t`, `execute_data_t`, the state enum `mem_state_t`, and the `msize_t` encoding.

Package `common`:
- `dbus_req_t` and `dbus_resp_t`.

Sub-module `muxword`:
- Combinational load extraction and extension.
- Inputs: raw bus data, `addr[2:0]`, size, unsigned flag.
- Output: the 64-bit result.
- Store strobe and data alignment stay inline.

## Test plan
- ALU pass-through: `add` with `result`=0x1234 → `dataM.writedata`=0x1234 on the next cycle, `stallM` never 1, `dreq.valid` never 1.
- Signed byte load: `lb` at addr 0x1003, bus returns 0x00000000_80000000 after 3 wait cycles → `writedata`=0xFFFF_FFFF_FFFF_FF80, `stallM` high for 3 cycles.
- Unsigned half store and load:
  - `sh` of 0xBEEF at 0x2006 → `strobe`=0xC0, `data`=0xBEEF_0000_0000_0000.
  - Subsequent `lhu` returns 0xBEEF.
- Reset mid-access: assert `reset`=0 during BUSY → next cycle `dreq.valid`=0, `dataM`=0, state IDLE. A late `data_ok` produces no `dataM` update.
- Back-to-back: `ld`, `sd`, `ld` with 0-wait bus → three requests with `addr`/`strobe` correct. `dataM` order matches program order, with one bubble between each.
- `MEM_MISALIGN_CHECK_EN`: `lw` at 0x1002 → `misalign`=1 for one cycle, no `dreq.valid`, `dataM.ctl.regwrite`=0.
